// File: rtl/alu_op_pkg.sv
// Shared ALU op encoding, arbiter FSM states and the muldiv classifier.
package alu_op_pkg;

  localparam int OPW = 5;

  typedef enum logic [OPW-1:0] {
    OP_ADD    = 5'd0,
    OP_SUB    = 5'd1,
    OP_SLL    = 5'd2,
    OP_SLT    = 5'd3,
    OP_SLTU   = 5'd4,
    OP_XOR    = 5'd5,
    OP_SRL    = 5'd6,
    OP_SRA    = 5'd7,
    OP_OR     = 5'd8,
    OP_AND    = 5'd9,
    OP_MUL    = 5'd10,
    OP_MULH   = 5'd11,
    OP_MULHSU = 5'd12,
    OP_MULHU  = 5'd13,
    OP_DIV    = 5'd14,
    OP_DIVU   = 5'd15,
    OP_REM    = 5'd16,
    OP_REMU   = 5'd17
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  // Multiply/divide ops occupy the contiguous code range MUL..REMU.
  function automatic logic is_muldiv(input logic [OPW-1:0] op);
    return (op >= OP_MUL) && (op <= OP_REMU);
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational integer ALU. Flags compare the operands, independent of op.
// Division by zero and signed overflow return placeholders; callers substitute.
module alu
  import alu_op_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [OPW-1:0] op,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [N-1:0]   data_out,
  output logic           zero,
  output logic           slt,
  output logic           sltu
);

  localparam int SW = $clog2(N);
  localparam logic [N-1:0] INT_MIN = {1'b1, {(N-1){1'b0}}};

  logic [2*N-1:0] p_ss, p_su, p_uu;
  logic [SW-1:0]  sh;
  logic [N-1:0]   b_udiv, b_sdiv;
  logic           sdiv_ovf;

  assign p_ss = {{N{a[N-1]}}, a} * {{N{b[N-1]}}, b};
  assign p_su = {{N{a[N-1]}}, a} * {{N{1'b0}}, b};
  assign p_uu = {{N{1'b0}}, a} * {{N{1'b0}}, b};
  assign sh   = b[SW-1:0];

  // Keep the dividers away from /0 and INT_MIN/-1 so the raw result is defined.
  assign sdiv_ovf = (a == INT_MIN) && (b == '1);
  assign b_udiv   = (b == '0) ? N'(1) : b;
  assign b_sdiv   = ((b == '0) || sdiv_ovf) ? N'(1) : b;

  assign zero = (a == b);
  assign slt  = ($signed(a) < $signed(b));
  assign sltu = (a < b);

  // Result select by op; unknown codes return zero.
  always_comb begin
    data_out = '0;
    case (op)
      OP_ADD:    data_out = a + b;
      OP_SUB:    data_out = a - b;
      OP_SLL:    data_out = a << sh;
      OP_SLT:    data_out = {{(N-1){1'b0}}, slt};
      OP_SLTU:   data_out = {{(N-1){1'b0}}, sltu};
      OP_XOR:    data_out = a ^ b;
      OP_SRL:    data_out = a >> sh;
      OP_SRA:    data_out = N'($signed(a) >>> sh);
      OP_OR:     data_out = a | b;
      OP_AND:    data_out = a & b;
      OP_MUL:    data_out = p_uu[N-1:0];
      OP_MULH:   data_out = p_ss[2*N-1:N];
      OP_MULHSU: data_out = p_su[2*N-1:N];
      OP_MULHU:  data_out = p_uu[2*N-1:N];
      OP_DIV:    data_out = N'($signed(a) / $signed(b_sdiv));
      OP_DIVU:   data_out = a / b_udiv;
      OP_REM:    data_out = N'($signed(a) % $signed(b_sdiv));
      OP_REMU:   data_out = a % b_udiv;
      default:   data_out = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin share of one ALU between NREQ requesters.
// Handshake: a request transfers on a cycle where req_valid[i] && req_ready[i];
// a response transfers on a cycle where rsp_valid && rsp_ready. req_ready is a
// combinational function of req_valid, so requesters must not gate req_valid
// on req_ready. rsp_* stay constant while rsp_valid is high and unacknowledged.
module alu_arbiter
  import alu_op_pkg::*;
#(
  parameter int  N      = 32,
  parameter int  NREQ   = 2,
  parameter int  LAT_MD = 4,
  localparam int IW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*OPW-1:0] req_op,
  input  logic [NREQ*N-1:0]   req_a,
  input  logic [NREQ*N-1:0]   req_b,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [IW-1:0]       rsp_id,
  output logic [N-1:0]        rsp_data,
  output logic                rsp_zero,
  output logic                rsp_slt,
  output logic                rsp_sltu,
  output logic                busy
);

  localparam int CW = (LAT_MD > 1) ? $clog2(LAT_MD) : 1;
  localparam logic [CW-1:0] CNT_MD  = CW'(LAT_MD - 1);
  localparam logic [N-1:0]  INT_MIN = {1'b1, {(N-1){1'b0}}};

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_EXEC = EXEC;
  localparam logic [1:0] ST_RESP = RESP;

  logic [1:0]     state;
  logic [IW-1:0]  last, grant, cand, id_q;
  logic           found, accept;
  logic [CW-1:0]  cnt;
  logic [OPW-1:0] op_q, sel_op;
  logic [N-1:0]   a_q, b_q, alu_data, result;
  logic           alu_zero, alu_slt, alu_sltu;

  // Round-robin search starting one past the last winner.
  always_comb begin
    found = 1'b0;
    grant = '0;
    cand  = last;
    for (int k = 0; k < NREQ; k++) begin
      cand = (cand == IW'(NREQ - 1)) ? '0 : cand + IW'(1);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        grant = cand;
      end
    end
  end

  // Single grant, only in IDLE and never while reset is held.
  always_comb begin
    req_ready = '0;
    if (rst_n && (state == ST_IDLE) && found) req_ready[grant] = 1'b1;
  end

  assign accept = |(req_valid & req_ready);
  assign sel_op = req_op[grant*OPW +: OPW];
  assign busy   = (state != ST_IDLE);

  alu #(.N(N)) u_alu (
    .op       (op_q),
    .a        (a_q),
    .b        (b_q),
    .data_out (alu_data),
    .zero     (alu_zero),
    .slt      (alu_slt),
    .sltu     (alu_sltu)
  );

  // RV32M substitutions for divide-by-zero and signed overflow.
  always_comb begin
    result = alu_data;
    case (op_q)
      OP_DIV: begin
        if (b_q == '0) result = '1;
        else if ((a_q == INT_MIN) && (b_q == '1)) result = INT_MIN;
      end
      OP_DIVU: if (b_q == '0) result = '1;
      OP_REM: begin
        if (b_q == '0) result = a_q;
        else if ((a_q == INT_MIN) && (b_q == '1)) result = '0;
      end
      OP_REMU: if (b_q == '0) result = a_q;
      default: result = alu_data;
    endcase
  end

  // FSM, operand latch, latency counter and registered response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      last      <= IW'(NREQ - 1);
      cnt       <= '0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      id_q      <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      rsp_zero  <= 1'b0;
      rsp_slt   <= 1'b0;
      rsp_sltu  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op_q  <= sel_op;
            a_q   <= req_a[grant*N +: N];
            b_q   <= req_b[grant*N +: N];
            id_q  <= grant;
            last  <= grant;
            cnt   <= is_muldiv(sel_op) ? CNT_MD : '0;
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (cnt == '0) begin
            rsp_valid <= 1'b1;
            rsp_id    <= id_q;
            rsp_data  <= result;
            rsp_zero  <= alu_zero;
            rsp_slt   <= alu_slt;
            rsp_sltu  <= alu_sltu;
            state     <= ST_RESP;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: stimulus pushes expected responses, a
// monitor pops and compares on every response handshake.
module tb_alu_arbiter;
  import alu_op_pkg::*;

  localparam int N = 32, NREQ = 2, LAT_MD = 4, IW = 1;
  localparam int EW = IW + N + 3;

  logic                clk, rst_n;
  logic [NREQ-1:0]     req_valid, req_ready;
  logic [NREQ*OPW-1:0] req_op;
  logic [NREQ*N-1:0]   req_a, req_b;
  logic                rsp_valid, rsp_ready;
  logic [IW-1:0]       rsp_id;
  logic [N-1:0]        rsp_data;
  logic                rsp_zero, rsp_slt, rsp_sltu, busy;

  alu_arbiter #(.N(N), .NREQ(NREQ), .LAT_MD(LAT_MD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_zero  (rsp_zero),
    .rsp_slt   (rsp_slt),
    .rsp_sltu  (rsp_sltu),
    .busy      (busy)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_fail   = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [EW-1:0] pack(input int id, input logic [N-1:0] d,
                                         input logic z, input logic s, input logic su);
    return {IW'(id), d, z, s, su};
  endfunction

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_rsp: id %0h data %0h with no expected entry", rsp_id, rsp_data);
      end else begin
        e = exp_q.pop_front();
        check("rsp_id",   rsp_id,   e[EW-1 -: IW]);
        check("rsp_data", rsp_data, e[N+2:3]);
        check("rsp_flags", {rsp_zero, rsp_slt, rsp_sltu}, e[2:0]);
      end
    end
  end

  // Driver tasks
  task automatic set_req(input int r, input logic [OPW-1:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
    req_valid[r]           = 1'b1;
    req_op[r*OPW +: OPW]   = op;
    req_a[r*N +: N]        = a;
    req_b[r*N +: N]        = b;
  endtask

  task automatic drop_req(input int r);
    req_valid[r] = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input int r);
    int t;
    t = 0;
    @(negedge clk);
    while (!req_ready[r] && t < 50) begin
      @(negedge clk);
      t++;
    end
    check($sformatf("grant_req%0d", r), req_ready[r], 1);
  endtask

  // Issue one request, wait for acceptance, then measure cycles to rsp_valid.
  task automatic send(input int r, input logic [OPW-1:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                      input logic [N-1:0] d, input logic z, input logic s, input logic su,
                      input int lat_exp, input string name);
    int lat;
    exp_q.push_back(pack(r, d, z, s, su));
    set_req(r, op, a, b);
    wait_ready(r);
    step();
    drop_req(r);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid && lat < 40);
    check({name, "_lat"}, lat, lat_exp);
  endtask

  initial begin
    int lat, t;
    logic blocked_ok;
    rst_n     = 1'b0;
    rsp_ready = 1'b1;
    req_valid = 2'b11;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_req_ready", req_ready, 2'b00);
    check("rst_outputs", {rsp_valid, rsp_id, rsp_data, rsp_zero, rsp_slt, rsp_sltu, busy}, '0);
    req_valid = '0;
    step();
    rst_n = 1'b1;
    step();

    // Single ADD
    send(0, OP_ADD, 32'd5, 32'd7, 32'd12, 1'b0, 1'b1, 1'b1, 2, "add");
    step();

    // Both requesters valid; fresh reset so requester 0 has priority
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    exp_q.push_back(pack(0, 32'd0,  1'b1, 1'b0, 1'b0));
    exp_q.push_back(pack(1, 32'hFF, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(pack(0, 32'h0F, 1'b0, 1'b0, 1'b0));
    set_req(0, OP_SUB, 32'd3, 32'd3);
    set_req(1, OP_XOR, 32'hF0, 32'h0F);
    wait_ready(0);
    check("rr_first", req_ready, 2'b01);
    step();
    set_req(0, OP_AND, 32'hFF, 32'h0F);
    wait_ready(1);
    check("rr_second", req_ready, 2'b10);
    step();
    drop_req(1);
    wait_ready(0);
    check("rr_third", req_ready, 2'b01);
    step();
    drop_req(0);
    repeat (3) step();

    // MULHU timing with requester 1 waiting
    exp_q.push_back(pack(0, 32'd1, 1'b0, 1'b1, 1'b0));
    set_req(0, OP_MULHU, 32'hFFFF_FFFF, 32'd2);
    wait_ready(0);
    step();
    drop_req(0);
    exp_q.push_back(pack(1, 32'd3, 1'b0, 1'b1, 1'b1));
    set_req(1, OP_OR, 32'd1, 32'd2);
    lat = 0;
    blocked_ok = 1'b1;
    do begin
      @(negedge clk);
      lat++;
      if (req_ready[1]) blocked_ok = 1'b0;
    end while (!rsp_valid && lat < 40);
    check("mulhu_lat", lat, LAT_MD + 1);
    check("mulhu_req1_blocked", blocked_ok, 1'b1);
    step();
    wait_ready(1);
    step();
    drop_req(1);
    repeat (3) step();

    // Overrides and other muldiv / unknown ops
    send(0, OP_DIV,  32'd10, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, LAT_MD + 1, "div_by0");
    step();
    send(0, OP_REMU, 32'd10, 32'd0, 32'd10, 1'b0, 1'b0, 1'b0, LAT_MD + 1, "remu_by0");
    step();
    send(0, OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b1, 1'b1, LAT_MD + 1, "div_ovf");
    step();
    send(0, OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1, 1'b1, LAT_MD + 1, "rem_ovf");
    step();
    send(0, OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 1'b1, 1'b0, LAT_MD + 1, "div_neg");
    step();
    send(0, OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, LAT_MD + 1, "rem_neg");
    step();
    send(0, OP_MUL, 32'd6, 32'd7, 32'd42, 1'b0, 1'b1, 1'b1, LAT_MD + 1, "mul");
    step();
    send(0, 5'h1F, 32'd3, 32'd3, 32'd0, 1'b1, 1'b0, 1'b0, 2, "nop");
    step();
    send(0, 5'd20, 32'd9, 32'd4, 32'd0, 1'b0, 1'b0, 1'b0, 2, "undef_op");
    step();

    // Backpressure
    rsp_ready = 1'b0;
    send(0, OP_ADD, 32'd1, 32'd1, 32'd2, 1'b1, 1'b0, 1'b0, 2, "bp_add");
    for (int i = 0; i < 6; i++) begin
      step();
      if (i == 0) set_req(1, OP_SLL, 32'd1, 32'd4);
      @(negedge clk);
      check("bp_hold", {rsp_valid, busy, rsp_id, rsp_data, rsp_zero, rsp_slt, rsp_sltu, req_ready},
            {1'b1, 1'b1, 1'b0, 32'd2, 1'b1, 1'b0, 1'b0, 2'b00});
    end
    exp_q.push_back(pack(1, 32'd16, 1'b0, 1'b1, 1'b1));
    step();
    rsp_ready = 1'b1;
    step();
    @(negedge clk);
    check("bp_release", {busy, rsp_valid, req_ready}, {1'b0, 1'b0, 2'b10});
    step();
    drop_req(1);
    repeat (3) step();

    // Reset during EXEC of DIVU: the op must never respond
    set_req(0, OP_DIVU, 32'd100, 32'd7);
    wait_ready(0);
    step();
    drop_req(0);
    step();
    rst_n = 1'b0;
    set_req(0, OP_SRA, 32'hFFFF_FF00, 32'd4);
    set_req(1, OP_SUB, 32'd10, 32'd3);
    @(negedge clk);
    check("rst_mid", {busy, rsp_valid, req_ready, rsp_id, rsp_data}, '0);
    step();
    rst_n = 1'b1;
    exp_q.push_back(pack(0, 32'hFFFF_FFF0, 1'b0, 1'b1, 1'b0));
    exp_q.push_back(pack(1, 32'd7, 1'b0, 1'b0, 1'b0));
    wait_ready(0);
    check("rst_prio", req_ready, 2'b01);
    step();
    drop_req(0);
    wait_ready(1);
    step();
    drop_req(1);
    repeat (4) step();

    // Final report
    t = 0;
    while (exp_q.size() != 0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
